clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYC, default 16, meaning idle cycles tolerated before the gate closes (legal range 1..255).
REQ-002 The block SHALL have parameter WAKE_CYC, default 2, meaning settle cycles after the gate reopens before ACK (legal range 1..255).
REQ-003 The block SHALL have port CLK, input, 1 bit: free-running clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port REQ, input, 1 bit: level request for gated clock, held by the consumer while it needs clock.
REQ-006 The block SHALL have port BUSY, input, 1 bit: consumer still has work in flight; it keeps or restores the clock like REQ.
REQ-007 The block SHALL have port SE, input, 1 bit: scan enable.
REQ-008 The block SHALL have port E, output, 1 bit: registered functional enable to the downstream clock-gate cell.
REQ-009 The block SHALL have port TE, output, 1 bit: test enable to the downstream clock-gate cell.
REQ-010 The block SHALL have port ACK, output, 1 bit: gated clock guaranteed running.

Function
REQ-011 The FSM SHALL have four states: RUN, IDLE, OFF and WAKE, driven by an 8-bit down-counter CNT.
REQ-012 In RUN, if REQ=0 and BUSY=0, the FSM SHALL go to IDLE and load CNT=IDLE_CYC-1; otherwise it SHALL stay in RUN.
REQ-013 In IDLE, if REQ|BUSY, the FSM SHALL go to RUN; else if CNT==0 it SHALL go to OFF; else CNT SHALL decrement. REQ|BUSY SHALL take priority over CNT==0.
REQ-014 In OFF, if REQ|BUSY, the FSM SHALL go to WAKE and load CNT=WAKE_CYC-1; otherwise it SHALL stay in OFF.
REQ-015 In WAKE, if CNT==0 the FSM SHALL go to RUN; else CNT SHALL decrement. A deassertion of REQ or BUSY during WAKE SHALL NOT abort it; the FSM completes to RUN and then follows REQ-012.
REQ-016 E SHALL be registered and equal 1 in RUN, IDLE and WAKE, and 0 in OFF.
REQ-017 ACK SHALL equal 1 only in RUN and SHALL be registered with the state.
REQ-018 TE SHALL equal SE combinationally; SE SHALL NOT affect the FSM, CNT or E.
REQ-019 Latency: E falls IDLE_CYC+1 rising edges after REQ=BUSY=0 is first sampled in RUN, and ACK rises WAKE_CYC+1 edges after REQ is first sampled in OFF.

Reset
REQ-020 While RST=1, the block SHALL hold state=RUN, CNT=0, E=1 and ACK=1, so the clock runs out of reset.
REQ-021 An assertion of RST in any state mid-count SHALL abandon the count immediately; the FSM resumes from RUN at the first rising edge after release.

Configuration
REQ-022 With CLK_GATE_CTRL_STATS_EN defined, the block SHALL add port GATE_CNT, output, 16 bits: the number of RUN/IDLE-to-OFF transitions, reset to 0, saturating at 0xFFFF.
REQ-023 Without CLK_GATE_CTRL_STATS_EN defined, the GATE_CNT port and its logic SHALL be absent.

Structure
REQ-024 The state enum (RUN, IDLE, OFF, WAKE) and the counter width constant CNT_W=8 SHALL live in package clk_gate_ctrl_pkg.
REQ-025 The load/decrement/zero-detect counter SHALL be one sub-module, clk_gate_dcnt, instantiated once and shared by IDLE and WAKE.

Verification
REQ-026 Reset: RST pulse mid-IDLE, REQ=0 -> during RST, E=1, ACK=1, state=RUN; after release, IDLE is re-entered next edge.
REQ-027 Gate off: IDLE_CYC=4, REQ falls in RUN, BUSY=0 -> E=0 at edge 5, ACK=0 from edge 1.
REQ-028 Idle abort: IDLE_CYC=4, REQ returns at the 3rd edge in IDLE -> back to RUN, E never 0, ACK=1.
REQ-029 Wake: WAKE_CYC=2, in OFF, BUSY pulses 1 cycle -> E=1 at edge 1, ACK=1 at edge 3, then IDLE sequence restarts.
REQ-030 Scan: SE toggles in all four states -> TE tracks SE, E and state unchanged versus the SE=0 run.
REQ-031 Stats (macro on): force 3 gate-off cycles -> GATE_CNT=3; preload 0xFFFF -> remains 0xFFFF after another gate-off.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate controller.
package clk_gate_ctrl_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {RUN, IDLE, OFF, WAKE} state_e;
endpackage

// File: rtl/clk_gate_dcnt.sv
// Loadable down-counter with zero detect, shared by the idle and wake timers.
module clk_gate_dcnt
  import clk_gate_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (dec && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-timeout clock-gate controller: closes the gate after IDLE_CYC quiet cycles,
// reopens on REQ/BUSY and acks after WAKE_CYC settle cycles. GATE_CNT under CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        BUSY,
  input  logic        SE,
  output logic        E,
  output logic        TE,
  output logic        ACK
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [15:0] GATE_CNT
`endif
);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);

  state_e           state_q, state_d;
  logic             e_q, e_d, ack_q, ack_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val, cnt_val;
  logic             wake_req;

  assign wake_req = REQ | BUSY;

  clk_gate_dcnt u_dcnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_ld_val),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = IDLE_LD;
    case (state_q)
      RUN: if (!wake_req) begin
        state_d  = IDLE;
        cnt_load = 1'b1;
      end
      // Activity wins over timeout expiry.
      IDLE: begin
        if (wake_req)      state_d = RUN;
        else if (cnt_zero) state_d = OFF;
        else               cnt_dec = 1'b1;
      end
      OFF: if (wake_req) begin
        state_d    = WAKE;
        cnt_load   = 1'b1;
        cnt_ld_val = WAKE_LD;
      end
      // Wake always runs to completion, even if the request drops.
      WAKE: begin
        if (cnt_zero) state_d = RUN;
        else          cnt_dec = 1'b1;
      end
      default: state_d = RUN;
    endcase
    e_d   = (state_d != OFF);
    ack_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      e_q     <= 1'b1;
      ack_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
    end
  end

  assign E   = e_q;
  assign ACK = ack_q;
  assign TE  = SE;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] gate_cnt_q, gate_cnt_d;

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    if ((state_q != OFF) && (state_d == OFF) && (gate_cnt_q != 16'hFFFF))
      gate_cnt_d = gate_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) gate_cnt_q <= '0;
    else     gate_cnt_q <= gate_cnt_d;
  end

  assign GATE_CNT = gate_cnt_q;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (IDLE_CYC=4, WAKE_CYC=2) with an expectation queue.
module tb_clk_gate_ctrl;
  import clk_gate_ctrl_pkg::*;

  logic CLK = 1'b0, RST, REQ, BUSY, SE;
  logic E, TE, ACK;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] GATE_CNT;
`endif

  typedef struct {
    logic  e;
    logic  ack;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;
  int   exp_gates = 0;
  logic last_exp_e = 1'b1;

  always #5 CLK = ~CLK;

  clk_gate_ctrl #(.IDLE_CYC(4), .WAKE_CYC(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .BUSY (BUSY),
    .SE   (SE),
    .E    (E),
    .TE   (TE),
    .ACK  (ACK)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .GATE_CNT (GATE_CNT)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    n_cmp++;
    assert (dut.state_q === exp) else begin
      n_fail++;
      $error("FAIL %s: state got %0d want %0d", tag, dut.state_q, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic step(input logic req, input logic busy, input logic se,
                      input logic exp_e, input logic exp_ack, input string tag);
    exp_t x;
    REQ = req; BUSY = busy; SE = se;
    #1;
    chk1({tag, ".te"}, TE, se);
    x.e = exp_e; x.ack = exp_ack; x.tag = tag;
    exp_q.push_back(x);
    if (last_exp_e && !exp_e) exp_gates++;
    last_exp_e = exp_e;
    @(posedge CLK);
    #1;
    x = exp_q.pop_front();
    chk1({x.tag, ".e"}, E, x.e);
    chk1({x.tag, ".ack"}, ACK, x.ack);
  endtask

  initial begin
    RST = 1'b1; REQ = 1'b1; BUSY = 1'b0; SE = 1'b0;
    #1;
    chk1("rst0.e", E, 1'b1);
    chk1("rst0.ack", ACK, 1'b1);
    chk_state("rst0.st", RUN);
    repeat (2) @(posedge CLK);
    #1;
    chk1("rst1.e", E, 1'b1);
    chk1("rst1.ack", ACK, 1'b1);
    RST = 1'b0;

    // Gate off: E drops on the 5th edge, ACK on the 1st.
    step(0, 0, 0, 1, 0, "off1");
    step(0, 0, 0, 1, 0, "off2");
    step(0, 0, 0, 1, 0, "off3");
    step(0, 0, 0, 1, 0, "off4");
    step(0, 0, 0, 0, 0, "off5");
    step(0, 0, 0, 0, 0, "off6");

    // Wake on a one-cycle BUSY pulse, then the idle sequence restarts.
    step(0, 1, 0, 1, 0, "wk1");
    step(0, 0, 0, 1, 0, "wk2");
    step(0, 0, 0, 1, 1, "wk3");
    step(0, 0, 0, 1, 0, "wk_idle1");
    step(0, 0, 0, 1, 0, "wk_idle2");
    step(0, 0, 0, 1, 0, "wk_idle3");
    step(0, 0, 0, 1, 0, "wk_idle4");
    step(0, 0, 0, 0, 0, "wk_idle5");

    // REQ wake that drops mid-wake still completes, then idle abort on 3rd IDLE edge.
    step(1, 0, 0, 1, 0, "wr1");
    step(0, 0, 0, 1, 0, "wr2");
    step(0, 0, 0, 1, 1, "wr3");
    step(0, 0, 0, 1, 0, "ab1");
    step(0, 0, 0, 1, 0, "ab2");
    step(1, 0, 0, 1, 1, "ab3");
    step(1, 0, 0, 1, 1, "ab4");

    // Scan enable toggling through every state leaves the sequence untouched.
    step(1, 0, 1, 1, 1, "sc_run");
    step(0, 0, 0, 1, 0, "sc_id1");
    step(0, 0, 1, 1, 0, "sc_id2");
    step(0, 0, 0, 1, 0, "sc_id3");
    step(0, 0, 1, 1, 0, "sc_id4");
    step(0, 0, 0, 0, 0, "sc_off1");
    step(0, 0, 1, 0, 0, "sc_off2");
    step(1, 0, 0, 1, 0, "sc_wk1");
    step(1, 0, 1, 1, 0, "sc_wk2");
    step(1, 0, 0, 1, 1, "sc_run2");

    // Reset mid-IDLE abandons the count; IDLE re-entered with a fresh count.
    step(0, 0, 0, 1, 0, "ri1");
    step(0, 0, 0, 1, 0, "ri2");
    RST = 1'b1;
    #1;
    chk1("ri_rst.e", E, 1'b1);
    chk1("ri_rst.ack", ACK, 1'b1);
    chk_state("ri_rst.st", RUN);
    step(0, 0, 0, 1, 1, "ri_hold");
    chk_state("ri_hold.st", RUN);
    RST = 1'b0;
    step(0, 0, 0, 1, 0, "ri_rel1");
    chk_state("ri_rel1.st", IDLE);
    step(0, 0, 0, 1, 0, "ri_rel2");
    step(0, 0, 0, 1, 0, "ri_rel3");
    step(0, 0, 0, 1, 0, "ri_rel4");
    step(0, 0, 0, 0, 0, "ri_rel5");

`ifdef CLK_GATE_CTRL_STATS_EN
    // The reset above cleared the counter; only the last gate-off counts.
    n_cmp++;
    assert (GATE_CNT === 16'd1) else begin
      n_fail++;
      $error("FAIL gcnt_after_rst: got %0d want 1", GATE_CNT);
    end
    repeat (2) begin
      step(1, 0, 0, 1, 0, "gs_w1");
      step(0, 0, 0, 1, 0, "gs_w2");
      step(0, 0, 0, 1, 1, "gs_w3");
      step(0, 0, 0, 1, 0, "gs_i1");
      step(0, 0, 0, 1, 0, "gs_i2");
      step(0, 0, 0, 1, 0, "gs_i3");
      step(0, 0, 0, 1, 0, "gs_i4");
      step(0, 0, 0, 0, 0, "gs_off");
    end
    n_cmp++;
    assert (GATE_CNT === 16'd3) else begin
      n_fail++;
      $error("FAIL gcnt3: got %0d want 3", GATE_CNT);
    end
    force dut.gate_cnt_q = 16'hFFFF;
    @(posedge CLK);
    #1;
    release dut.gate_cnt_q;
    step(1, 0, 0, 1, 0, "sat_w1");
    step(0, 0, 0, 1, 0, "sat_w2");
    step(0, 0, 0, 1, 1, "sat_w3");
    step(0, 0, 0, 1, 0, "sat_i1");
    step(0, 0, 0, 1, 0, "sat_i2");
    step(0, 0, 0, 1, 0, "sat_i3");
    step(0, 0, 0, 1, 0, "sat_i4");
    step(0, 0, 0, 0, 0, "sat_off");
    n_cmp++;
    assert (GATE_CNT === 16'hFFFF) else begin
      n_fail++;
      $error("FAIL gcnt_sat: got %h want ffff", GATE_CNT);
    end
`endif

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
